// File: rtl/up_down_counter_ctrl_pkg.sv
// up_down_counter_ctrl_pkg: opcodes, state encoding and default width for the counter sequencer
package up_down_counter_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_UP     = 2'd1;
  localparam logic [1:0] OP_DOWN   = 2'd2;
  localparam logic [1:0] OP_BOUNCE = 2'd3;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_UP   = 3'd1,
    RUN_DOWN = 3'd2,
    B_UP     = 3'd3,
    B_DOWN   = 3'd4
  } state_t;
endpackage

// File: rtl/updown_counter_core.sv
// updown_counter_core: count register with load and modulo +/-1 step
module updown_counter_core
  import up_down_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= dir ? count + 1'b1 : count - 1'b1;
endmodule

// File: rtl/up_down_counter_ctrl.sv
// up_down_counter_ctrl: command-driven sequencer stepping an up/down counter
module up_down_counter_ctrl
  import up_down_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [WIDTH-1:0] remaining, target;
  logic en, dir, load, last;
  assign cmd_ready = state == IDLE && !abort && !rst;
  assign busy = state != IDLE;
  always_comb begin
    load = cmd_valid && cmd_ready && cmd_op == OP_LOAD;
    dir  = state == RUN_UP || (state == B_UP && count < target);
    en   = !abort && (((state == RUN_UP || state == RUN_DOWN) && remaining != '0) ||
                      (state == B_UP && (count < target || count != '0)) ||
                      (state == B_DOWN && count != '0));
    last = count == '0 || count == WIDTH'(1);
  end
  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(cmd_arg), .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      target    <= '0;
      up_down   <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) state <= IDLE;
      else unique case (state)
        IDLE: if (cmd_valid) unique case (cmd_op)
          OP_LOAD: done <= 1'b1;
          OP_UP: begin
            remaining <= cmd_arg;
            state     <= RUN_UP;
            up_down   <= 1'b1;
          end
          OP_DOWN: begin
            remaining <= cmd_arg;
            state     <= RUN_DOWN;
            up_down   <= 1'b0;
          end
          default: begin
            target  <= cmd_arg;
            state   <= B_UP;
            up_down <= 1'b1;
          end
        endcase
        RUN_UP, RUN_DOWN: begin
          if (remaining != '0) remaining <= remaining - 1'b1;
          if (remaining == '0 || remaining == WIDTH'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        B_UP: if (count >= target) begin
          if (count != '0) up_down <= 1'b0;
          state <= last ? IDLE : B_DOWN;
          done  <= last;
        end
        B_DOWN: if (last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
